// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: control bit map,
// default field widths and the packed slice payload.
package pipe_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;

  localparam int CTRL_W_DEF = 4;
  // Memdata + ALUResult + RDaddr
  localparam int DATA_W_DEF = 2 * XLEN + REGADDR_W;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [DATA_W_DEF-1:0] data;
  } slice_payload_t;

  // True when a control word would change architectural state.
  function automatic logic has_side_effect(input logic [CTRL_W_DEF-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One valid/ctrl/data register slice. Flush and bubbles zero valid and ctrl;
// data is left alone on flush.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Slice state: reset, flush-to-bubble, or capture on load.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end else if (load_i) begin
      valid_r <= valid_i;
      ctrl_r  <= valid_i ? ctrl_i : {CTRL_W{1'b0}};
      data_r  <= data_i;
    end else begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
      data_r  <= data_r;
    end
  end

  assign valid_o = valid_r;
  assign ctrl_o  = ctrl_r;
  assign data_o  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic STAGES-deep pipeline register with valid/ready handshake, global
// stall and flush, and an occupancy counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STAGES = 1,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] load_s;
  logic [CTRL_W-1:0] ctrl_s [STAGES];
  logic [DATA_W-1:0] data_s [STAGES];
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic [CNT_W-1:0]  count_r;

  // Ready chain from the output back to slice 0; a slice loads when empty or drained.
  always_comb begin
    logic take_v;
    take_v = ready_i;
    load_s = {STAGES{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      load_s[k] = !valid_s[k] || take_v;
      take_v    = load_s[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic              valid_in_s;
    logic [CTRL_W-1:0] ctrl_in_s;
    logic [DATA_W-1:0] data_in_s;

    if (k == 0) begin : g_head
      assign valid_in_s = valid_i;
      assign ctrl_in_s  = ctrl_i;
      assign data_in_s  = data_i;
    end else begin : g_body
      assign valid_in_s = valid_s[k-1];
      assign ctrl_in_s  = ctrl_s[k-1];
      assign data_in_s  = data_s[k-1];
    end

    pipe_slice #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slice (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .load_i  (load_s[k] && !stall_i),
      .valid_i (valid_in_s),
      .ctrl_i  (ctrl_in_s),
      .data_i  (data_in_s),
      .valid_o (valid_s[k]),
      .ctrl_o  (ctrl_s[k]),
      .data_o  (data_s[k])
    );
  end

  assign ready_o    = !stall_i && !flush_i && load_s[0];
  assign in_xfer_s  = valid_i && ready_o;
  assign out_xfer_s = valid_s[STAGES-1] && ready_i && !stall_i;

  // Occupancy: net of accepted and delivered entries; flush empties the pipe.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + CNT_W'(in_xfer_s) - CNT_W'(out_xfer_s);
    end
  end

  assign valid_o = valid_s[STAGES-1];
  assign ctrl_o  = ctrl_s[STAGES-1];
  assign data_o  = data_s[STAGES-1];
  assign count_o = count_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a 3-slice and a 2-slice instance
// share stimulus, each tracked by its own scoreboard queue.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic        ready_dn;
  logic [3:0]  ctrl_in;
  logic [68:0] data_in;

  logic        r3, v3, r2, v2;
  logic [3:0]  c3, c2;
  logic [68:0] d3, d2;
  logic [1:0]  n3, n2;

  slice_payload_t q3[$];
  slice_payload_t q2[$];
  slice_payload_t exp_p;
  int total, bad, n_out3, n_out2;

  always #5 clk = ~clk;

  pipe_stage_reg #(.STAGES(3)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(valid_in), .ready_o(r3), .ctrl_i(ctrl_in), .data_i(data_in),
    .valid_o(v3), .ready_i(ready_dn), .ctrl_o(c3), .data_o(d3), .count_o(n3)
  );

  pipe_stage_reg #(.STAGES(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(valid_in), .ready_o(r2), .ctrl_i(ctrl_in), .data_i(data_in),
    .valid_o(v2), .ready_i(ready_dn), .ctrl_o(c2), .data_o(d2), .count_o(n2)
  );

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ready_dn = 1'b1;
    valid_in = 1'b1; ctrl_in = 4'hF; data_in = {69{1'b1}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (v3 !== 1'b0 || c3 !== 4'h0 || d3 !== 69'd0 || n3 !== 2'd0) begin
      bad++;
      $display("FAIL reset_dut3 got v=%b c=%h d=%h n=%0d want all 0", v3, c3, d3, n3);
    end
    total++;
    if (v2 !== 1'b0 || c2 !== 4'h0 || d2 !== 69'd0 || n2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_dut2 got v=%b c=%h d=%h n=%0d want all 0", v2, c2, d2, n2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; valid_in = 1'b0; ctrl_in = 4'h0; data_in = 69'd0;
    @(negedge clk);
    total++;
    if (r3 !== 1'b1 || v3 !== 1'b0 || n3 !== 2'd0) begin
      bad++;
      $display("FAIL reset_release got ready=%b v=%b n=%0d want 1 0 0", r3, v3, n3);
    end
  endtask

  task automatic test_stream();
    int exp_cnt[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      valid_in = (i < 4);
      data_in  = 69'(i + 1);
      ctrl_in  = 4'(i * 3 + 1);
      @(negedge clk);
      total++;
      if (int'(n3) !== exp_cnt[i]) begin
        bad++;
        $display("FAIL stream_count[%0d] got=%0d want=%0d", i, n3, exp_cnt[i]);
      end
      if (i >= 3 && i <= 6) begin
        total++;
        if (v3 !== 1'b1 || d3 !== 69'(i - 2)) begin
          bad++;
          $display("FAIL stream_out[%0d] got v=%b d=%0d want v=1 d=%0d", i, v3, d3, i - 2);
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_backpressure();
    int item = 1;
    int start_out = n_out3;
    logic exp_ready;
    for (int c = 0; c < 40 && (item <= 6 || q3.size() != 0); c++) begin
      @(posedge clk); #1;
      ready_dn = !(c >= 2 && c < 6);
      valid_in = (item <= 6);
      data_in  = 69'(item);
      ctrl_in  = 4'(item) ^ 4'hA;
      @(negedge clk);
      exp_ready = ready_dn || (q3.size() < 3);
      total++;
      if (r3 !== exp_ready) begin
        bad++;
        $display("FAIL bp_ready[%0d] got=%b want=%b", c, r3, exp_ready);
      end
      if (valid_in && r3) item++;
    end
    total++;
    if (item != 7 || q3.size() != 0) begin
      bad++;
      $display("FAIL bp_drain got item=%0d left=%0d want 7 0", item, q3.size());
    end
    total++;
    if (n_out3 - start_out != 6) begin
      bad++;
      $display("FAIL bp_delivered got=%0d want=6", n_out3 - start_out);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; ready_dn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_stall();
    int item = 101;
    for (int c = 0; c < 30 && (item <= 106 || q2.size() != 0); c++) begin
      @(posedge clk); #1;
      stall    = (c >= 3 && c < 6);
      valid_in = (item <= 106);
      data_in  = 69'(item);
      ctrl_in  = 4'(item);
      @(negedge clk);
      if (stall) begin
        total++;
        if (r2 !== 1'b0 || r3 !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready[%0d] got r2=%b r3=%b want 0 0", c, r2, r3);
        end
        total++;
        if (q2.size() == 0 || v2 !== 1'b1 || {c2, d2} !== q2[0]) begin
          bad++;
          $display("FAIL stall_hold[%0d] got v=%b d=%0d want v=1 d=%0d", c, v2, d2,
                   (q2.size() != 0) ? q2[0].data : 69'd0);
        end
      end
      if (valid_in && r2) item++;
    end
    total++;
    if (item != 107 || q2.size() != 0) begin
      bad++;
      $display("FAIL stall_drain got item=%0d left=%0d want 107 0", item, q2.size());
    end
    @(posedge clk); #1;
    stall = 1'b0; valid_in = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_flush();
    ready_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1; ctrl_in = 4'b0001; data_in = 69'(11 + i);
    end
    @(posedge clk); #1;
    valid_in = 1'b1; ctrl_in = 4'hF; data_in = 69'hAA; flush = 1'b1; stall = 1'b1;
    @(negedge clk);
    total++;
    if (r3 !== 1'b0 || r2 !== 1'b0 || n3 !== 2'd3) begin
      bad++;
      $display("FAIL flush_pre got r3=%b r2=%b n3=%0d want 0 0 3", r3, r2, n3);
    end
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    total++;
    if (v3 !== 1'b0 || c3 !== 4'h0 || n3 !== 2'd0 || v2 !== 1'b0 || n2 !== 2'd0) begin
      bad++;
      $display("FAIL flush_kill got v3=%b c3=%h n3=%0d v2=%b n2=%0d want 0 0 0 0 0",
               v3, c3, n3, v2, n2);
    end
    total++;
    if (d3 !== 69'd11) begin
      bad++;
      $display("FAIL flush_data_hold got=%0d want=11", d3);
    end
    ready_dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (v3 !== 1'b0 || v2 !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_capture[%0d] got v3=%b v2=%b want 0 0", i, v3, v2);
      end
    end
  endtask

  task automatic test_bubble();
    logic [3:0]  pat_c[4] = '{4'h1, 4'hF, 4'h9, 4'h0};
    logic        pat_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      valid_in = (i < 4) ? pat_v[i] : 1'b0;
      ctrl_in  = (i < 4) ? pat_c[i] : 4'h0;
      data_in  = 69'(21 + i);
      @(negedge clk);
      if (i == 3 || i == 5) begin
        total++;
        if (v3 !== 1'b1 || d3 !== 69'(18 + i)) begin
          bad++;
          $display("FAIL bubble_neighbour[%0d] got v=%b d=%0d want v=1 d=%0d", i, v3, d3, 18 + i);
        end
      end
      if (i == 4) begin
        total++;
        if (v3 !== 1'b0 || c3 !== 4'h0 || has_side_effect(c3) !== 1'b0) begin
          bad++;
          $display("FAIL bubble_out got v=%b c=%h want v=0 c=0", v3, c3);
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; n_out3 = 0; n_out2 = 0;
    rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
          q3.delete(); q2.delete();
        end else begin
          total++;
          if (int'(n3) != q3.size()) begin
            bad++;
            $display("FAIL sb_count3 got=%0d want=%0d", n3, q3.size());
          end
          total++;
          if (int'(n2) != q2.size()) begin
            bad++;
            $display("FAIL sb_count2 got=%0d want=%0d", n2, q2.size());
          end
          if (!v3) begin
            total++;
            if (c3 !== 4'h0) begin
              bad++;
              $display("FAIL sb_idle_ctrl3 got=%h want=0", c3);
            end
          end
          if (v3 && ready_dn && !stall) begin
            total++;
            if (q3.size() == 0) begin
              bad++;
              $display("FAIL sb_extra3 got d=%0d want none", d3);
            end else begin
              exp_p = q3.pop_front();
              n_out3++;
              if ({c3, d3} !== exp_p) begin
                bad++;
                $display("FAIL sb_out3 got c=%h d=%0d want c=%h d=%0d", c3, d3, exp_p.ctrl, exp_p.data);
              end
            end
          end
          if (v2 && ready_dn && !stall) begin
            total++;
            if (q2.size() == 0) begin
              bad++;
              $display("FAIL sb_extra2 got d=%0d want none", d2);
            end else begin
              exp_p = q2.pop_front();
              n_out2++;
              if ({c2, d2} !== exp_p) begin
                bad++;
                $display("FAIL sb_out2 got c=%h d=%0d want c=%h d=%0d", c2, d2, exp_p.ctrl, exp_p.data);
              end
            end
          end
          if (flush) begin
            q3.delete(); q2.delete();
          end else begin
            if (valid_in && r3) q3.push_back('{ctrl: ctrl_in, data: data_in});
            if (valid_in && r2) q2.push_back('{ctrl: ctrl_in, data: data_in});
          end
        end
      end
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_bubble();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
